// File: rtl/bk_sector_seq_if.sv
// Sector handshake between the save-state sequencer and hps_io.
// The sequencer issues sd_lba/sd_rd/sd_wr, and hps_io answers with sd_ack.
interface bk_sector_seq_if;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;

    modport master (
        output sd_lba,
        output sd_rd,
        output sd_wr,
        input  sd_ack
    );

    modport slave (
        input  sd_lba,
        input  sd_rd,
        input  sd_wr,
        output sd_ack
    );
endinterface

// File: rtl/bk_sector_seq.sv
// Save-state sequencer: walks every sector of a save slot through the hps_io sector handshake.
// Optional ack watchdog is enabled by defining BK_TIMEOUT_EN.
module bk_sector_seq #(
    parameter int unsigned SEC_LOG2 = 6,
    parameter int unsigned SLOT_W   = 2
`ifdef BK_TIMEOUT_EN
    ,
    parameter int unsigned TMO_W    = 24
`endif
) (
    input  logic              clk_sys_i,
    input  logic              reset_n_i,
    input  logic              bk_ena_i,
    input  logic              load_req_i,
    input  logic              save_req_i,
    input  logic [SLOT_W-1:0] slot_i,
    bk_sector_seq_if.master   sd,
    output logic              bk_loading_o,
    output logic              bk_state_o,
    output logic              bk_done_o,
    output logic              bk_err_o
);

    localparam int unsigned LBA_PAD = 32 - SEC_LOG2 - SLOT_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_DONE
    } state_e;

    state_e              state_q;
    logic                arm_q;
    logic                ld_q;
    logic                sv_q;
    logic                ack_q;
    logic [SLOT_W-1:0]   slot_q;
    logic [SEC_LOG2-1:0] idx_q;
    logic [SEC_LOG2-1:0] idx_d;
    logic                rd_q;
    logic                wr_q;
    logic                loading_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    logic ld_lvl;
    logic sv_lvl;
    logic ld_start;
    logic sv_start;
    logic start;
    logic ack_rise;
    logic ack_fall;
    logic last_sec;
    logic tmo_expired;

    assign ld_lvl   = load_req_i & bk_ena_i;
    assign sv_lvl   = save_req_i & bk_ena_i;
    // arm_q masks the first cycle after reset so a level already high at release is not an edge
    assign ld_start = arm_q & ld_lvl & ~ld_q;
    assign sv_start = arm_q & sv_lvl & ~sv_q;
    assign start    = ld_start | sv_start;
    assign ack_rise = sd.sd_ack & ~ack_q;
    assign ack_fall = ~sd.sd_ack & ack_q;
    assign last_sec = (idx_q == {SEC_LOG2{1'b1}});
    assign idx_d    = idx_q + {{(SEC_LOG2-1){1'b0}}, 1'b1};

`ifdef BK_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q;
    logic             waiting;
    logic             step_evt;

    assign waiting     = (state_q == S_REQ) || (state_q == S_XFER);
    assign step_evt    = ((state_q == S_REQ) && ack_rise) || ((state_q == S_XFER) && ack_fall);
    assign tmo_expired = waiting && (tmo_q == {TMO_W{1'b1}});

    // Restarts from zero whenever the FSM changes state, so it measures time spent in one state
    always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tmo_q <= '0;
        end else if (!waiting || step_evt || tmo_expired) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
        end
    end
`else
    assign tmo_expired = 1'b0;
`endif

    always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= S_IDLE;
            arm_q     <= 1'b0;
            ld_q      <= 1'b0;
            sv_q      <= 1'b0;
            ack_q     <= 1'b0;
            slot_q    <= '0;
            idx_q     <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            loading_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            arm_q <= 1'b1;
            ld_q  <= ld_lvl;
            sv_q  <= sv_lvl;
            ack_q <= sd.sd_ack;

            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        slot_q    <= slot_i;
                        idx_q     <= '0;
                        busy_q    <= 1'b1;
                        loading_q <= ld_start;
                        rd_q      <= ld_start;
                        wr_q      <= ~ld_start;
                        err_q     <= 1'b0;
                        state_q   <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (ack_rise) begin
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        state_q <= S_XFER;
                    end else if (tmo_expired) begin
                        rd_q      <= 1'b0;
                        wr_q      <= 1'b0;
                        busy_q    <= 1'b0;
                        loading_q <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end

                S_XFER: begin
                    if (ack_fall) begin
                        if (last_sec) begin
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            loading_q <= 1'b0;
                            state_q   <= S_DONE;
                        end else begin
                            idx_q   <= idx_d;
                            rd_q    <= loading_q;
                            wr_q    <= ~loading_q;
                            state_q <= S_REQ;
                        end
                    end else if (tmo_expired) begin
                        busy_q    <= 1'b0;
                        loading_q <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end

                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sd.sd_lba    = {{LBA_PAD{1'b0}}, slot_q, idx_q};
    assign sd.sd_rd     = rd_q;
    assign sd.sd_wr     = wr_q;
    assign bk_loading_o = loading_q;
    assign bk_state_o   = busy_q;
    assign bk_done_o    = done_q;
    assign bk_err_o     = err_q;

endmodule

// File: tb/tb_bk_sector_seq.sv
// Testbench for bk_sector_seq: autonomous hps_io ack model plus a scoreboard of expected sector requests.
// Define BK_TIMEOUT_EN to also exercise the ack watchdog (built with TMO_W=8).
module tb_bk_sector_seq;

    typedef struct {
        logic [31:0] lba;
        bit          isLoad;
    } exp_t;

    logic       clk;
    logic       resetN;
    logic       bkEna;
    logic       loadReq;
    logic       saveReq;
    logic [1:0] slot;
    logic       bkLoading;
    logic       bkState;
    logic       bkDone;
    logic       bkErr;

    bit   ackEn;
    bit   reqPrev;
    int   doneCnt;
    int   checkCnt;
    int   passCnt;
    exp_t expQ[$];

    bk_sector_seq_if bus ();

    bk_sector_seq #(
        .SEC_LOG2(6),
        .SLOT_W  (2)
`ifdef BK_TIMEOUT_EN
        ,
        .TMO_W   (8)
`endif
    ) dut (
        .clk_sys_i   (clk),
        .reset_n_i   (resetN),
        .bk_ena_i    (bkEna),
        .load_req_i  (loadReq),
        .save_req_i  (saveReq),
        .slot_i      (slot),
        .sd          (bus),
        .bk_loading_o(bkLoading),
        .bk_state_o  (bkState),
        .bk_done_o   (bkDone),
        .bk_err_o    (bkErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "[TB] global timeout");
    end

    // hps_io stand-in: 3 cycles after a request, hold ack high for 4 cycles
    initial begin
        bus.sd_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ackEn && (bus.sd_rd || bus.sd_wr)) begin
                repeat (3) @(negedge clk);
                bus.sd_ack = 1'b1;
                repeat (4) @(negedge clk);
                bus.sd_ack = 1'b0;
            end
        end
    end

    // Scoreboard: every new request is matched against the oldest expected sector
    always @(negedge clk) begin
        if (!resetN) begin
            reqPrev = 1'b0;
        end else begin
            if ((bus.sd_rd || bus.sd_wr) && !reqPrev) begin
                checkCnt++;
                if (expQ.size() == 0) begin
                    $display("[TB] FAIL unexpected_req: lba=%h rd=%b wr=%b, required no request",
                             bus.sd_lba, bus.sd_rd, bus.sd_wr);
                end else begin
                    exp_t e;
                    passCnt++;
                    e = expQ.pop_front();
                    checkCnt++;
                    if (bus.sd_lba !== e.lba)
                        $display("[TB] FAIL req_lba: got %h, required %h", bus.sd_lba, e.lba);
                    else passCnt++;
                    checkCnt++;
                    if (bus.sd_rd !== e.isLoad || bus.sd_wr !== !e.isLoad)
                        $display("[TB] FAIL req_dir: got rd=%b wr=%b, required rd=%b wr=%b",
                                 bus.sd_rd, bus.sd_wr, e.isLoad, !e.isLoad);
                    else passCnt++;
                    checkCnt++;
                    if (bkLoading !== e.isLoad || bkState !== 1'b1)
                        $display("[TB] FAIL req_flags: got loading=%b state=%b, required loading=%b state=1",
                                 bkLoading, bkState, e.isLoad);
                    else passCnt++;
                end
            end
            reqPrev = bus.sd_rd || bus.sd_wr;
            if (bkDone === 1'b1) doneCnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] base, input bit isLoad);
        for (int i = 0; i < 64; i++) expQ.push_back('{lba: base + 32'(i), isLoad: isLoad});
    endtask

    // Waits for the falling ack of the final outstanding sector; no comparisons here
    task automatic waitLastAck(output bit ok);
        bit prevAck = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick(1);
            if (prevAck && !bus.sd_ack && expQ.size() == 0) begin
                ok = 1'b1;
                return;
            end
            prevAck = bus.sd_ack;
        end
    endtask

    task automatic test_reset;
        resetN  = 1'b0;
        bkEna   = 1'b1;
        loadReq = 1'b1;
        saveReq = 1'b0;
        slot    = 2'd0;
        tick(3);
        checkCnt++;
        if ({bus.sd_rd, bus.sd_wr, bkLoading, bkState, bkDone, bkErr} !== 6'b0 || bus.sd_lba !== 32'h0)
            $display("[TB] FAIL reset_outputs: got rd=%b wr=%b ld=%b st=%b dn=%b er=%b lba=%h, required all 0",
                     bus.sd_rd, bus.sd_wr, bkLoading, bkState, bkDone, bkErr, bus.sd_lba);
        else passCnt++;
        resetN = 1'b1;
        tick(8);
        checkCnt++;
        if (bkState !== 1'b0 || bus.sd_rd !== 1'b0)
            $display("[TB] FAIL reset_level_start: got state=%b rd=%b, required 0 0", bkState, bus.sd_rd);
        else passCnt++;
        loadReq = 1'b0;
        tick(2);
    endtask

    task automatic test_load;
        bit ok;
        int d0 = doneCnt;
        slot = 2'd2;
        applyStimulus(32'h80, 1'b1);
        loadReq = 1'b1;
        tick(1);
        checkCnt++;
        if (bus.sd_rd !== 1'b1 || bus.sd_lba !== 32'h80)
            $display("[TB] FAIL load_latency: got rd=%b lba=%h, required rd=1 lba=00000080", bus.sd_rd, bus.sd_lba);
        else passCnt++;
        tick(20);
        slot  = 2'd3;
        bkEna = 1'b0;
        waitLastAck(ok);
        checkCnt++;
        if (!ok) begin
            $display("[TB] FAIL load_last_ack: timed out with %0d sectors left, required 0", expQ.size());
            expQ.delete();
        end else if (bkDone !== 1'b1 || bkState !== 1'b0 || bkLoading !== 1'b0)
            $display("[TB] FAIL load_done: got done=%b state=%b loading=%b, required 1 0 0", bkDone, bkState, bkLoading);
        else passCnt++;
        tick(1);
        checkCnt++;
        if (bkDone !== 1'b0)
            $display("[TB] FAIL load_done_pulse: got done=%b one cycle later, required 0", bkDone);
        else passCnt++;
        loadReq = 1'b0;
        tick(2);
        bkEna = 1'b1;
        tick(4);
        checkCnt++;
        if (doneCnt - d0 !== 1 || bkState !== 1'b0)
            $display("[TB] FAIL load_done_count: got %0d pulses state=%b, required 1 pulse state=0", doneCnt - d0, bkState);
        else passCnt++;
    endtask

    task automatic test_save;
        bit ok;
        int d0 = doneCnt;
        slot = 2'd0;
        applyStimulus(32'h00, 1'b0);
        saveReq = 1'b1;
        tick(1);
        checkCnt++;
        if (bus.sd_wr !== 1'b1 || bus.sd_rd !== 1'b0 || bkLoading !== 1'b0 || bkState !== 1'b1)
            $display("[TB] FAIL save_start: got wr=%b rd=%b loading=%b state=%b, required 1 0 0 1",
                     bus.sd_wr, bus.sd_rd, bkLoading, bkState);
        else passCnt++;
        waitLastAck(ok);
        checkCnt++;
        if (!ok) begin
            $display("[TB] FAIL save_last_ack: timed out with %0d sectors left, required 0", expQ.size());
            expQ.delete();
        end else if (bkDone !== 1'b1)
            $display("[TB] FAIL save_done: got done=%b after last ack fall, required 1", bkDone);
        else passCnt++;
        saveReq = 1'b0;
        tick(4);
        checkCnt++;
        if (doneCnt - d0 !== 1)
            $display("[TB] FAIL save_done_count: got %0d pulses, required 1", doneCnt - d0);
        else passCnt++;
    endtask

    task automatic test_both_edges;
        bit ok;
        bit sawBusy = 1'b0;
        slot = 2'd1;
        applyStimulus(32'h40, 1'b1);
        loadReq = 1'b1;
        saveReq = 1'b1;
        tick(1);
        checkCnt++;
        if (bus.sd_rd !== 1'b1 || bus.sd_wr !== 1'b0 || bus.sd_lba !== 32'h40)
            $display("[TB] FAIL both_load_wins: got rd=%b wr=%b lba=%h, required rd=1 wr=0 lba=00000040",
                     bus.sd_rd, bus.sd_wr, bus.sd_lba);
        else passCnt++;
        waitLastAck(ok);
        if (!ok) expQ.delete();
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (bkState === 1'b1) sawBusy = 1'b1;
        end
        checkCnt++;
        if (!ok || sawBusy)
            $display("[TB] FAIL both_save_lost: got finished=%b busy_after=%b, required 1 0", ok, sawBusy);
        else passCnt++;
        loadReq = 1'b0;
        saveReq = 1'b0;
        tick(2);
    endtask

    task automatic test_gating;
        bit ok;
        bit sawBusy = 1'b0;
        int d0;
        bkEna = 1'b0;
        tick(2);
        loadReq = 1'b1;
        tick(2);
        loadReq = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (bkState === 1'b1 || bus.sd_rd === 1'b1) sawBusy = 1'b1;
        end
        checkCnt++;
        if (sawBusy)
            $display("[TB] FAIL gate_disabled: got activity with bk_ena=0, required none");
        else passCnt++;
        bkEna = 1'b1;
        tick(2);
        d0   = doneCnt;
        slot = 2'd3;
        applyStimulus(32'hC0, 1'b1);
        loadReq = 1'b1;
        tick(30);
        saveReq = 1'b1;
        tick(2);
        saveReq = 1'b0;
        waitLastAck(ok);
        checkCnt++;
        if (!ok) begin
            $display("[TB] FAIL gate_busy_save: timed out with %0d sectors left, required 0", expQ.size());
            expQ.delete();
        end else if (bkDone !== 1'b1)
            $display("[TB] FAIL gate_busy_done: got done=%b, required 1", bkDone);
        else passCnt++;
        loadReq = 1'b0;
        tick(10);
        checkCnt++;
        if (doneCnt - d0 !== 1 || bkState !== 1'b0)
            $display("[TB] FAIL gate_done_count: got %0d pulses state=%b, required 1 pulse state=0", doneCnt - d0, bkState);
        else passCnt++;
    endtask

    task automatic test_reset_midop;
        bit hit = 1'b0;
        bit sawBusy = 1'b0;
        int d0 = doneCnt;
        slot = 2'd0;
        applyStimulus(32'h00, 1'b1);
        loadReq = 1'b1;
        for (int c = 0; c < 2000 && !hit; c++) begin
            tick(1);
            if (expQ.size() == 53 && bus.sd_ack === 1'b1) hit = 1'b1;
        end
        #3;
        resetN = 1'b0;
        #1;
        checkCnt++;
        if (!hit)
            $display("[TB] FAIL midreset_reach: sector 10 ack never seen, required it within budget");
        else if ({bus.sd_rd, bus.sd_wr, bkLoading, bkState, bkDone, bkErr} !== 6'b0 || bus.sd_lba !== 32'h0)
            $display("[TB] FAIL midreset_async: got rd=%b wr=%b ld=%b st=%b dn=%b er=%b lba=%h, required all 0",
                     bus.sd_rd, bus.sd_wr, bkLoading, bkState, bkDone, bkErr, bus.sd_lba);
        else passCnt++;
        expQ.delete();
        tick(3);
        resetN = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (bkState === 1'b1 || bus.sd_rd === 1'b1) sawBusy = 1'b1;
        end
        checkCnt++;
        if (sawBusy || doneCnt != d0)
            $display("[TB] FAIL midreset_restart: got busy=%b done_pulses=%0d, required 0 0", sawBusy, doneCnt - d0);
        else passCnt++;
        loadReq = 1'b0;
        tick(2);
    endtask

`ifdef BK_TIMEOUT_EN
    task automatic test_timeout;
        bit ok;
        int busyCycles = 0;
        int d0 = doneCnt;
        ackEn = 1'b0;
        slot  = 2'd1;
        expQ.push_back('{lba: 32'h40, isLoad: 1'b1});
        loadReq = 1'b1;
        tick(1);
        while (bkState === 1'b1 && busyCycles < 400) begin
            busyCycles++;
            tick(1);
        end
        checkCnt++;
        if (busyCycles < 255 || busyCycles > 257)
            $display("[TB] FAIL tmo_duration: got %0d busy cycles, required 255..257", busyCycles);
        else passCnt++;
        checkCnt++;
        if (bus.sd_rd !== 1'b0 || bkErr !== 1'b1 || bkLoading !== 1'b0 || doneCnt != d0)
            $display("[TB] FAIL tmo_abort: got rd=%b err=%b loading=%b done_pulses=%0d, required 0 1 0 0",
                     bus.sd_rd, bkErr, bkLoading, doneCnt - d0);
        else passCnt++;
        loadReq = 1'b0;
        ackEn   = 1'b1;
        tick(3);
        checkCnt++;
        if (bkErr !== 1'b1)
            $display("[TB] FAIL tmo_sticky: got err=%b in idle, required 1", bkErr);
        else passCnt++;
        slot = 2'd0;
        applyStimulus(32'h00, 1'b0);
        saveReq = 1'b1;
        tick(1);
        checkCnt++;
        if (bkErr !== 1'b0)
            $display("[TB] FAIL tmo_clear: got err=%b after new start, required 0", bkErr);
        else passCnt++;
        waitLastAck(ok);
        checkCnt++;
        if (!ok) begin
            $display("[TB] FAIL tmo_recover: timed out with %0d sectors left, required 0", expQ.size());
            expQ.delete();
        end else if (bkDone !== 1'b1)
            $display("[TB] FAIL tmo_recover_done: got done=%b, required 1", bkDone);
        else passCnt++;
        saveReq = 1'b0;
        tick(3);
    endtask
`endif

    initial begin
        checkCnt = 0;
        passCnt  = 0;
        doneCnt  = 0;
        reqPrev  = 1'b0;
        ackEn    = 1'b1;
        test_reset();
        test_load();
        test_save();
        test_both_edges();
        test_gating();
        test_reset_midop();
`ifdef BK_TIMEOUT_EN
        test_timeout();
`endif
        checkCnt++;
        if (expQ.size() != 0)
            $display("[TB] FAIL scoreboard_drain: got %0d unmatched sectors, required 0", expQ.size());
        else passCnt++;
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
